// File: rtl/rom_loader_if.sv
// rtl/rom_loader_if.sv - download stream and ROM RAM bus bundle
interface rom_loader_if #(
    parameter int AW = 13
);
    logic          dl_valid;
    logic [7:0]    dl_data;
    logic          dl_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    // Download source and ROM RAM side
    modport master (
        output dl_valid, dl_data, mem_rdata,
        input  dl_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side
    modport slave (
        input  dl_valid, dl_data, mem_rdata,
        output dl_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - byte-serial ROM image writer with readback checksum verify
module rom_loader #(
    parameter int AW    = 13,
    parameter int DEPTH = 8192
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    rom_loader_if.slave       bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       checksum,
    output logic              cpu_hold
);
    // One spare bit so the verify counter can reach DEPTH+1 even when DEPTH == 2^AW.
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST_W  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] FIRST_R = CW'(2);
    localparam logic [CW-1:0] LAST_R  = CW'(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  wcnt;
    logic [CW-1:0]  vcnt;
    logic [15:0]    sum;
    logic [15:0]    rsum;
    logic [AW-1:0]  addr_q;
    logic           we_q;
    logic [7:0]     wdata_q;

    logic           xfer;
    logic           last_xfer;
    logic           rd_cap;
    logic           rd_last;
    logic           rd_match;
    logic [15:0]    sum_nx;

    assign bus.dl_ready  = (state == S_LOAD);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    // Address k goes out at verify count k, the RAM registers it one edge later,
    // and its data is summed on the edge after that: counts 2..DEPTH+1.
    assign xfer      = (state == S_LOAD) && bus.dl_valid;
    assign last_xfer = xfer && (wcnt == LAST_W);
    assign rd_cap    = (state == S_VERIFY) && (vcnt >= FIRST_R);
    assign rd_last   = (state == S_VERIFY) && (vcnt == LAST_R);
    assign rd_match  = ((rsum + {8'h00, bus.mem_rdata}) == checksum);
    assign sum_nx    = sum + {8'h00, bus.dl_data};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (last_xfer) state_nx = S_VERIFY;
            end
            S_VERIFY: begin
                if (rd_last) state_nx = rd_match ? S_DONE : S_ERROR;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Registered outputs, counters and running sums
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            checksum <= '0;
            cpu_hold <= 1'b1;
            wcnt     <= '0;
            vcnt     <= '0;
            sum      <= '0;
            rsum     <= '0;
        end else begin
            we_q <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        wcnt     <= '0;
                        sum      <= '0;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        cpu_hold <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        we_q    <= 1'b1;
                        addr_q  <= wcnt[AW-1:0];
                        wdata_q <= bus.dl_data;
                        sum     <= sum_nx;
                        wcnt    <= wcnt + 1'b1;
                    end
                    if (last_xfer) begin
                        checksum <= sum_nx;
                        vcnt     <= '0;
                        rsum     <= '0;
                    end
                end
                S_VERIFY: begin
                    vcnt <= vcnt + 1'b1;
                    if (vcnt < DEPTH_C) addr_q <= vcnt[AW-1:0];
                    if (rd_cap) rsum <= rsum + {8'h00, bus.mem_rdata};
                    if (rd_last) begin
                        busy <= 1'b0;
                        if (rd_match) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            error    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - scoreboard bench for rom_loader at DEPTH 16 and 8192
module tb_rom_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start16 = 1'b0;
    logic        start8k = 1'b0;
    logic        busy16, done16, err16, hold16;
    logic        busy8k, done8k, err8k, hold8k;
    logic [15:0] sum16, sum8k;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          w16 = 0;
    int          w8k = 0;
    bit          corrupt16 = 1'b0;
    logic [20:0] sb[$];
    logic [7:0]  ram16 [0:8191];
    logic [7:0]  ram8k [0:8191];

    rom_loader_if #(.AW(13)) b16 ();
    rom_loader_if #(.AW(13)) b8k ();

    rom_loader #(.AW(13), .DEPTH(16)) u16 (
        .clk(clk), .reset(reset), .start(start16), .bus(b16),
        .busy(busy16), .done(done16), .error(err16), .checksum(sum16), .cpu_hold(hold16)
    );

    rom_loader #(.AW(13), .DEPTH(8192)) u8k (
        .clk(clk), .reset(reset), .start(start8k), .bus(b8k),
        .busy(busy8k), .done(done8k), .error(err8k), .checksum(sum8k), .cpu_hold(hold8k)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Ideal synchronous RAMs; the small one can corrupt address 7 on read
    always @(posedge clk) begin
        if (b16.mem_we) ram16[b16.mem_addr] <= b16.mem_wdata;
        b16.mem_rdata <= (corrupt16 && b16.mem_addr == 13'd7) ? 8'hFF : ram16[b16.mem_addr];
        if (b8k.mem_we) ram8k[b8k.mem_addr] <= b8k.mem_wdata;
        b8k.mem_rdata <= ram8k[b8k.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write-strobe monitors: small DUT against the scoreboard, large DUT against order
    always @(negedge clk) begin
        if (b16.mem_we) begin
            chk("w16_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                logic [20:0] e;
                e = sb.pop_front();
                chk("w16_addr", 32'(b16.mem_addr), 32'(e[20:8]));
                chk("w16_data", 32'(b16.mem_wdata), 32'(e[7:0]));
            end
            w16++;
        end
        if (b8k.mem_we) begin
            chk("w8k_addr", 32'(b8k.mem_addr), 32'(w8k));
            chk("w8k_data", 32'(b8k.mem_wdata), 32'h0000_00FF);
            w8k++;
        end
    end

    task automatic run16(input int gap_pct, input bit mid_start, input int abort_at, output int lat);
        int acc, s, vc;
        bit fin;
        acc = 0; vc = 0; lat = -1; fin = 1'b0;
        sb.delete();
        w16 = 0;
        @(negedge clk); start16 = 1'b1;
        @(negedge clk); start16 = 1'b0; s = cyc;
        chk("start_hold", 32'(hold16), 32'd1);
        chk("start_busy", 32'(busy16), 32'd1);
        chk("start_done", 32'({done16, err16}), 32'd0);
        chk("start_ready", 32'(b16.dl_ready), 32'd1);
        for (int n = 0; n < 400 && !fin; n++) begin
            if (done16 || err16) begin
                lat = cyc - s;
                fin = 1'b1;
            end else begin
                if (acc >= 16) begin
                    chk("ready_after_last", 32'(b16.dl_ready), 32'd0);
                    vc++;
                    if (abort_at > 0 && vc == abort_at) begin
                        reset = 1'b1;
                        @(negedge clk); reset = 1'b0;
                        chk("abort_ready", 32'(b16.dl_ready), 32'd0);
                        chk("abort_we", 32'(b16.mem_we), 32'd0);
                        chk("abort_addr", 32'(b16.mem_addr), 32'd0);
                        chk("abort_wdata", 32'(b16.mem_wdata), 32'd0);
                        chk("abort_flags", 32'({busy16, done16, err16}), 32'd0);
                        chk("abort_sum", 32'(sum16), 32'd0);
                        chk("abort_hold", 32'(hold16), 32'd1);
                        lat = 0;
                        fin = 1'b1;
                    end
                end
                if (!fin) begin
                    b16.dl_valid = (acc >= 16) ? 1'b1 : ($urandom_range(99) >= gap_pct);
                    b16.dl_data  = (acc >= 16) ? 8'hAA : 8'(acc);
                    start16      = mid_start && (acc == 5);
                    if (b16.dl_valid && b16.dl_ready) begin
                        sb.push_back({13'(acc), 8'(acc)});
                        acc++;
                    end
                    @(negedge clk);
                end
            end
        end
        b16.dl_valid = 1'b0;
        start16 = 1'b0;
        chk("run16_finished", 32'(fin), 32'd1);
    endtask

    task automatic post16(input bit ok);
        chk("done", 32'(done16), 32'(ok));
        chk("error", 32'(err16), 32'(!ok));
        chk("cpu_hold", 32'(hold16), 32'(!ok));
        chk("busy_end", 32'(busy16), 32'd0);
        chk("checksum16", 32'(sum16), 32'h0000_0078);
        chk("write_count", 32'(w16), 32'd16);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int lat, acc, n;
        b16.dl_valid = 1'b0; b16.dl_data = 8'h00;
        b8k.dl_valid = 1'b0; b8k.dl_data = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_ready", 32'(b16.dl_ready), 32'd0);
        chk("rst_we", 32'(b16.mem_we), 32'd0);
        chk("rst_addr", 32'(b16.mem_addr), 32'd0);
        chk("rst_wdata", 32'(b16.mem_wdata), 32'd0);
        chk("rst_flags", 32'({busy16, done16, err16}), 32'd0);
        chk("rst_sum", 32'(sum16), 32'd0);
        chk("rst_hold", 32'(hold16), 32'd1);

        run16(0, 1'b0, -1, lat);
        chk("latency_done", 32'(lat), 32'd34);
        post16(1'b1);

        run16(40, 1'b0, -1, lat);
        post16(1'b1);

        corrupt16 = 1'b1;
        run16(0, 1'b0, -1, lat);
        chk("latency_error", 32'(lat), 32'd34);
        post16(1'b0);
        corrupt16 = 1'b0;

        run16(0, 1'b0, 5, lat);
        run16(30, 1'b1, -1, lat);
        post16(1'b1);

        run16(0, 1'b1, -1, lat);
        chk("latency_reload", 32'(lat), 32'd34);
        post16(1'b1);

        @(negedge clk); start8k = 1'b1;
        @(negedge clk); start8k = 1'b0;
        acc = 0;
        w8k = 0;
        for (n = 0; n < 20000; n++) begin
            if (done8k || err8k) break;
            b8k.dl_valid = 1'b1;
            b8k.dl_data  = 8'hFF;
            if (b8k.dl_ready) acc++;
            @(negedge clk);
        end
        b8k.dl_valid = 1'b0;
        chk("8k_finished", 32'(n < 20000), 32'd1);
        chk("8k_done", 32'(done8k), 32'd1);
        chk("8k_error", 32'(err8k), 32'd0);
        chk("8k_hold", 32'(hold8k), 32'd0);
        chk("8k_checksum", 32'(sum8k), 32'h0000_E000);
        chk("8k_accepted", 32'(acc), 32'd8192);
        chk("8k_writes", 32'(w8k), 32'd8192);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Writer side of the 8 KB game ROM images: accepts a byte-serial download stream and writes it sequentially into a RAM-backed ROM (13-bit address, 8-bit data, synchronous 1-cycle read).
- Reads the image back to verify a 16-bit additive checksum.
- Holds the CPU in reset until a verified image is present.
- One instance per ROM chip (e.g. 4D/4E pair), sitting between the download port and the ROM RAM.

Parameters:
- AW, 13, address width of the target ROM.
- DEPTH, 8192, number of bytes loaded and verified; must satisfy 2 <= DEPTH <= 2^AW.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load.
- dl_valid  in  1  download byte valid.
- dl_data  in  8  download byte.
- dl_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  ROM RAM write strobe.
- mem_addr  out  AW  ROM RAM address, used for both write and read.
- mem_wdata  out  8  ROM RAM write data.
- mem_rdata  in  8  ROM RAM read data; valid the cycle after mem_addr is presented.
- busy  out  1  load or verify in progress.
- done  out  1  image loaded and verified.
- error  out  1  verify checksum mismatch.
- checksum  out  16  sum of all downloaded bytes, mod 2^16.
- cpu_hold  out  1  hold the CPU in reset.

Behaviour:
- Reset: state goes to IDLE. On the next edge, dl_ready, mem_we, mem_addr, mem_wdata, busy, done, error and checksum are all 0, and cpu_hold is 1. Reset takes priority in every state and aborts a load or verify in progress.
- States: IDLE, LOAD, VERIFY, DONE, ERROR. All outputs are registered, except dl_ready, which is decoded from state (high only in LOAD).
- IDLE/DONE/ERROR -> LOAD on start:
  - Clears the write counter, sum, done and error.
  - Sets busy=1 and cpu_hold=1.
  - start is ignored in LOAD and VERIFY.
- LOAD:
  - A transfer occurs on an edge where dl_valid && dl_ready.
  - On the edge after transfer n, outputs show mem_we=1, mem_addr=n, mem_wdata=byte; otherwise mem_we=0. Write latency is 1 cycle.
  - Each transferred byte is added to a 16-bit sum, wrapping mod 2^16.
  - Bubbles on dl_valid are allowed, and addresses never skip.
- LOAD -> VERIFY:
  - The edge accepting byte DEPTH-1 moves to VERIFY, so dl_ready is 0 in the next cycle. Bytes beyond DEPTH are never accepted.
  - checksum is registered with the final sum on that edge.
- VERIFY:
  - mem_we=0. mem_addr steps 0..DEPTH-1, one per cycle, starting the cycle after the final write strobe.
  - mem_rdata for address k is captured one cycle after address k is presented and added to a 16-bit read sum.
  - After the read data for DEPTH-1 is captured (DEPTH+1 cycles after VERIFY entry), the read sum is compared with checksum.
  - Equal -> DONE; unequal -> ERROR.
- DONE: busy=0, done=1, cpu_hold=0. Remains here until start or reset.
- ERROR: busy=0, error=1, cpu_hold=1. Remains here until start or reset.
- mem_addr keeps its last value whenever it is not stepping.
- With DEPTH < 2^AW, addresses at or above DEPTH are never written.

Test Plan:
- DEPTH=16, stream bytes 0x00..0x0F with dl_valid held high -> 16 consecutive write strobes at addr 0..15, checksum=0x0078, an ideal RAM model returns matching data, done=1 and cpu_hold=0 at cycle 1+16+17 after start.
- DEPTH=16 with random dl_valid gaps -> writes contiguous and in order, identical checksum, dl_ready never high after byte 15.
- DEPTH=16, RAM model corrupts addr 7 (reads 0xFF instead of 0x07) -> error=1, done=0, cpu_hold=1, checksum still 0x0078.
- DEPTH=8192, all bytes 0xFF -> checksum=(8192*255) mod 65536=0xE000 (wrap), done=1.
- Assert reset during VERIFY -> next edge: all outputs 0, cpu_hold=1. A subsequent start reloads cleanly to done.
- start pulsed mid-LOAD -> ignored, address sequence unbroken. start after DONE -> cpu_hold returns to 1 and a second load completes.
